// File: rtl/motores_pwm.sv
// H-bridge driver for the L298: PWM speed control, timed moves counted in PWM
// periods, and a forced coast interval whenever the bridge pattern changes.
module motores_pwm #(
  parameter int CNT_W       = 8,
  parameter int DUR_W       = 16,
  parameter int DEAD_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mov,
  input  logic [CNT_W-1:0] cmd_duty,
  input  logic [DUR_W-1:0] cmd_dur,
  output logic [3:0]       IN,
  output logic [1:0]       EN,
  output logic             busy,
  output logic             done
);

  localparam int                DEAD_W    = $clog2(DEAD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [3:0]        PAT_FRENO = 4'b1111;

  typedef enum logic [1:0] {IDLE, DEAD, RUN} state_t;

  state_t             state, state_d;
  logic [3:0]         pat_q, pat_d, new_pat;
  logic [CNT_W-1:0]   duty_q, duty_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [DEAD_W-1:0]  dead_cnt, dead_d;
  logic               done_d;
  logic               accept;

  function automatic logic [3:0] decode(input logic [2:0] mov);
    case (mov)
      3'd1:    decode = 4'b1001;  // RETROCESO
      3'd2:    decode = 4'b0110;  // AVANCE
      3'd3:    decode = 4'b0101;  // GIROD
      3'd4:    decode = 4'b1010;  // GIROI
      3'd5:    decode = PAT_FRENO;
      default: decode = 4'b0000;  // PAUSA and unused codes
    endcase
  endfunction

  assign cmd_ready = (state != DEAD);
  assign accept    = cmd_valid && cmd_ready;
  assign new_pat   = decode(cmd_mov);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state;
    pat_d   = pat_q;
    duty_d  = duty_q;
    dur_d   = dur_q;
    cnt_d   = cnt;
    dead_d  = dead_cnt;
    done_d  = 1'b0;

    if (accept) begin
      // A new command always wins over an expiring timed move.
      pat_d  = new_pat;
      duty_d = cmd_duty;
      dur_d  = cmd_dur;
      cnt_d  = '0;
      dead_d = '0;
      if (new_pat == 4'b0000)                     state_d = IDLE;
      else if (state == RUN && new_pat != pat_q)  state_d = DEAD;
      else                                        state_d = RUN;
    end else begin
      case (state)
        DEAD: begin
          if (dead_cnt == DEAD_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            dead_d = dead_cnt + DEAD_W'(1);
          end
        end
        RUN: begin
          cnt_d = cnt + CNT_W'(1);
          if (cnt == CNT_MAX && dur_q != '0) begin
            dur_d = dur_q - DUR_W'(1);
            if (dur_q == DUR_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pat_q    <= '0;
      duty_q   <= '0;
      dur_q    <= '0;
      cnt      <= '0;
      dead_cnt <= '0;
      IN       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      pat_q    <= pat_d;
      duty_q   <= duty_d;
      dur_q    <= dur_d;
      cnt      <= cnt_d;
      dead_cnt <= dead_d;
      IN       <= (state_d == RUN) ? pat_d : 4'b0000;
      busy     <= (state_d != IDLE);
      done     <= done_d;
    end
  end

  // Enables depend only on registered state, so there is no input-to-output path.
  assign EN = (state != RUN)       ? 2'b00 :
              (pat_q == PAT_FRENO) ? 2'b11 :
                                     {2{cnt < duty_q}};

endmodule

// File: tb/tb_motores_pwm.sv
// Directed bench for motores_pwm with CNT_W=4 (16-cycle PWM period) and a
// 4-cycle coast interval; expected values are hand-derived per step.
module tb_motores_pwm;

  localparam int CNT_W = 4;
  localparam int DUR_W = 16;
  localparam int DEAD  = 4;
  localparam int P     = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_mov;
  logic [CNT_W-1:0] cmd_duty;
  logic [DUR_W-1:0] cmd_dur;
  logic [3:0]       in_pins;
  logic [1:0]       en_pins;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  motores_pwm #(.CNT_W(CNT_W), .DUR_W(DUR_W), .DEAD_CYCLES(DEAD)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mov   (cmd_mov),
    .cmd_duty  (cmd_duty),
    .cmd_dur   (cmd_dur),
    .IN        (in_pins),
    .EN        (en_pins),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one edge; afterwards we sit in the first cycle after acceptance.
  task automatic issue(input logic [2:0] mov, input logic [CNT_W-1:0] duty, input logic [DUR_W-1:0] dur);
    check("ready_at_issue", 16'(cmd_ready), 16'h1);
    cmd_valid = 1'b1;
    cmd_mov   = mov;
    cmd_duty  = duty;
    cmd_dur   = dur;
    step();
    cmd_valid = 1'b0;
  endtask

  // Checks n RUN cycles starting at cnt=0: EN high while (i % P) < hi.
  task automatic run_window(input string tag, input logic [3:0] pat, input int n, input int hi);
    for (int i = 0; i < n; i++) begin
      check({tag, "_in"}, 16'(in_pins), 16'(pat));
      check({tag, "_en"}, 16'(en_pins), ((i % P) < hi) ? 16'h3 : 16'h0);
      check({tag, "_done"}, 16'(done), 16'h0);
      step();
    end
  endtask

  task automatic dead_window(input string tag);
    for (int i = 0; i < DEAD; i++) begin
      check({tag, "_in"}, 16'(in_pins), 16'h0);
      check({tag, "_en"}, 16'(en_pins), 16'h0);
      check({tag, "_ready"}, 16'(cmd_ready), 16'h0);
      check({tag, "_busy"}, 16'(busy), 16'h1);
      step();
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_mov   = '0;
    cmd_duty  = '0;
    cmd_dur   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("por_in", 16'(in_pins), 16'h0);
    check("por_en", 16'(en_pins), 16'h0);
    check("por_busy", 16'(busy), 16'h0);
    check("por_done", 16'(done), 16'h0);
    rst = 1'b0;
    step();
    check("por_ready", 16'(cmd_ready), 16'h1);

    // 1. async reset mid-RUN
    issue(3'd2, 4'd15, 16'd0);
    repeat (3) step();
    check("pre_rst_in", 16'(in_pins), 16'h6);
    rst = 1'b1;
    #1;
    check("rst_in", 16'(in_pins), 16'h0);
    check("rst_en", 16'(en_pins), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    #2;
    rst = 1'b0;
    step();
    check("rst_ready", 16'(cmd_ready), 16'h1);
    check("rst_idle_busy", 16'(busy), 16'h0);

    // 2. timed AVANCE, duty 4, two periods
    issue(3'd2, 4'd4, 16'd2);
    run_window("timed", 4'b0110, 2 * P, 4);
    check("timed_done", 16'(done), 16'h1);
    check("timed_busy", 16'(busy), 16'h0);
    check("timed_in", 16'(in_pins), 16'h0);
    check("timed_en", 16'(en_pins), 16'h0);
    step();
    check("timed_done_clr", 16'(done), 16'h0);

    // 3. AVANCE then RETROCESO mid-period: coast, then restart at cnt=0
    issue(3'd2, 4'd8, 16'd0);
    repeat (5) step();
    check("adv_in", 16'(in_pins), 16'h6);
    issue(3'd1, 4'd8, 16'd0);
    dead_window("dead_ret");
    run_window("ret", 4'b1001, P, 8);

    // 4. same-pattern preemption: no coast, counter restarts
    issue(3'd0, 4'd0, 16'd0);
    check("pausa_busy", 16'(busy), 16'h0);
    check("pausa_done", 16'(done), 16'h0);
    issue(3'd2, 4'd4, 16'd0);
    repeat (6) step();
    issue(3'd2, 4'd12, 16'd0);
    check("pre_ready", 16'(cmd_ready), 16'h1);
    run_window("pre", 4'b0110, P, 12);

    // 5. GIROD then FRENO, then code 7 back to IDLE
    issue(3'd3, 4'd3, 16'd0);
    dead_window("dead_gd");
    run_window("girod", 4'b0101, P, 3);
    issue(3'd5, 4'd0, 16'd0);
    dead_window("dead_fr");
    run_window("freno", 4'b1111, P, P);
    issue(3'd7, 4'd9, 16'd0);
    check("c7_in", 16'(in_pins), 16'h0);
    check("c7_en", 16'(en_pins), 16'h0);
    check("c7_busy", 16'(busy), 16'h0);
    check("c7_done", 16'(done), 16'h0);
    step();
    check("c7_done2", 16'(done), 16'h0);

    // 6. duty extremes, then a command on the expiry edge of dur=1
    issue(3'd2, 4'd0, 16'd0);
    run_window("duty0", 4'b0110, P, 0);
    issue(3'd2, 4'd15, 16'd0);
    run_window("duty15", 4'b0110, P, 15);
    issue(3'd0, 4'd0, 16'd0);
    issue(3'd2, 4'd4, 16'd1);
    repeat (P - 1) step();
    issue(3'd2, 4'd4, 16'd0);
    check("exp_done", 16'(done), 16'h0);
    check("exp_busy", 16'(busy), 16'h1);
    run_window("exp", 4'b0110, 2 * P, 4);
    check("exp_still_busy", 16'(busy), 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/motores_pwm.md
# motores_pwm

Next-generation H-bridge motor driver for the mapping robot SoC. It adds three things to plain direction decoding: PWM speed control, timed moves counted in PWM periods, and a mandatory dead-time (coast) interval whenever the bridge pattern changes. It accepts commands over a valid/ready handshake from the CPU-side register wrapper and drives the L298 module directly: IN[3:0] for direction and EN[1:0] for the ENA/ENB PWM.

## Interface
- CNT_W, 8: PWM counter width; PWM period P = 2^CNT_W cycles.
- DUR_W, 16: width of the move duration field, in PWM periods.
- DEAD_CYCLES, 64: coast cycles inserted on a bridge pattern change; must be ≥ 1.
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted at a clock edge where valid && ready.
- cmd_mov  in  3  movement code.
- cmd_duty  in  CNT_W  PWM duty threshold.
- cmd_dur  in  DUR_W  duration in PWM periods; 0 = run until the next command.
- IN  out  4  L298 inputs: IN[3]→IN1, IN[2]→IN2, IN[1]→IN3, IN[0]→IN4. Motor A = {IN1,IN2}, motor B = {IN3,IN4}.
- EN  out  2  EN[1]→ENA, EN[0]→ENB.
- busy  out  1  high when state ≠ IDLE.
- done  out  1  one-cycle pulse when a timed move completes.

## Operation
- Movement codes map to bridge patterns:
  - 0 PAUSA → 0000
  - 1 RETROCESO → 1001
  - 2 AVANCE → 0110
  - 3 GIROD → 0101
  - 4 GIROI → 1010
  - 5 FRENO → 1111
  - 6 and 7 are treated as PAUSA.
- States: IDLE, DEAD, RUN.
  - IDLE: IN=0000, EN=00.
  - DEAD: IN=0000, EN=00.
  - RUN: IN=pat_q; EN={pwm,pwm} with pwm = (cnt < duty_q). For FRENO, EN=11 regardless of duty.
- cmd_ready = (state ≠ DEAD). Commands arriving in RUN preempt the current move.
- On acceptance, pat_q, duty_q and dur_q are latched, then:
  - PAUSA: go to IDLE. No done pulse.
  - From IDLE: go to RUN.
  - From RUN with new pattern = pat_q: stay in RUN with new duty/dur; cnt restarts at 0.
  - From RUN with new pattern ≠ pat_q: go to DEAD for exactly DEAD_CYCLES cycles, then RUN.
- cnt is CNT_W bits. It is 0 in the first RUN cycle and increments every RUN cycle, wrapping at 2^CNT_W−1.
- Timed move (dur_q ≠ 0): at each RUN edge where cnt = 2^CNT_W−1, dur_q decrements.
  - When the decrement is from 1, the next state is IDLE and done is high for the following cycle.
  - RUN therefore lasts exactly dur × P cycles.
- Duty arithmetic is an unsigned compare.
  - duty 0: EN stays low for the whole period.
  - duty 2^CNT_W−1: EN is high for P−1 of P cycles.
- A pattern change never drives a non-zero pattern directly after a different non-zero pattern; DEAD always intervenes.

## Timing
- Reset (async assert, any state): IN=0000, EN=00, busy=0, done=0, state=IDLE, all counters and latched fields cleared. Takes effect immediately without a clock. cmd_ready=1 from the first edge after deassertion.
- IN, busy and done are registered. EN is decoded combinationally from the registered state, cnt, duty_q and pat_q only; it has no input-to-output path.
- Accept in IDLE at edge t: RUN and the new IN are visible from t+1.
- Accept in RUN with a pattern change at edge t: DEAD during cycles t+1 … t+DEAD_CYCLES; RUN from t+DEAD_CYCLES+1.
- cmd_valid held during DEAD is not accepted until ready rises. Fields must be held stable while valid && !ready.
- If a command is accepted on the same edge where a timed move would expire, the command wins: no done pulse, transition per the acceptance rules.
- dur_q = 2^DUR_W−1 is legal and does not overflow.

## Test plan
Bench parameters: CNT_W=4, DEAD_CYCLES=4.
1. Reset: assert rst mid-RUN → IN=0000 and EN=00 asynchronously; busy=0. After release, cmd_ready=1.
2. AVANCE, duty=4, dur=2 from IDLE → IN=0110 for 32 cycles; EN=11 for cycles 0–3 and 16–19 of RUN, else 00; then IDLE with a single-cycle done.
3. AVANCE continuous, then RETROCESO accepted mid-period → exactly 4 cycles of IN=0000/EN=00 with cmd_ready=0; then IN=1001 with cnt=0.
4. AVANCE duty=4, then AVANCE duty=12 preempting → no DEAD cycles; EN high for 12 of 16 cycles from restart.
5. FRENO after GIROD → 4 DEAD cycles, then IN=1111, EN=11 regardless of duty. PAUSA or code 7 → IDLE next cycle, no done pulse.
6. Edge cases: duty=0 → EN always 00 while IN=0110; duty=15 → EN low only when cnt=15. A command accepted on the expiry edge of dur=1 → no done pulse.
